// File: rtl/bit_packer.sv
// Serial-to-parallel packer: LSB-first bits are assembled into WIDTH-bit words
// and buffered in a first-word fall-through FIFO with a sticky overflow flag.
module bit_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_bit,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] word_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;

    // The word pushed on the last-bit edge must already include that bit.
    always_comb begin
        word_next          = shift_reg;
        word_next[bit_cnt] = i_bit;
    end

    assign push   = i_en && (bit_cnt == CW'(WIDTH - 1));
    assign full   = (o_count == NW'(DEPTH));
    assign pop    = o_valid && i_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (i_en) begin
            shift_reg <= word_next;
            bit_cnt   <= push ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)
                o_count <= o_count + NW'(1);
            else if (pop && !accept)
                o_count <= o_count - NW'(1);
            if (push && !accept)
                o_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: o_data is masked until a word has been written.
    always_ff @(posedge i_clk) begin
        if (accept) mem[wr_ptr] <= word_next;
    end

    assign o_valid = (o_count != '0);
    assign o_data  = o_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_bit_packer.sv
// Randomized and directed checks of bit_packer against a queue-based model.
module tb_bit_packer;

    localparam int W = 8;
    localparam int D = 4;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_en;
    logic         i_bit;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic [2:0]   o_count;
    logic         o_overflow;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    int           m_nbits;
    logic [W-1:0] m_acc;
    bit           m_ovf;
    int           cyc = 0;

    bit_packer #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_bit     (i_bit),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_count   (o_count),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset;
        mq.delete();
        got.delete();
        m_nbits = 0;
        m_acc   = '0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle, log any word handed over, and advance the model.
    task automatic tick(input logic en, input logic b, input logic rdy);
        bit           pop_m;
        bit           push_m;
        logic [W-1:0] w;
        @(negedge i_clk);
        i_en = en; i_bit = b; i_ready = rdy;
        if (o_valid && rdy) got.push_back(o_data);
        @(posedge i_clk);
        cyc++;
        pop_m  = (mq.size() != 0) && rdy;
        push_m = 1'b0;
        w      = '0;
        if (en) begin
            m_acc = m_acc | (W'(b) << m_nbits);
            if (m_nbits == W - 1) begin
                push_m  = 1'b1;
                w       = m_acc;
                m_acc   = '0;
                m_nbits = 0;
            end else begin
                m_nbits++;
            end
        end
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            if (mq.size() < D) mq.push_back(w);
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset;
        @(negedge i_clk);
        i_rst = 1'b1; i_en = 1'b0; i_ready = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_en = 1'b0; i_bit = 1'b0; i_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        tests++;
        if ({o_valid, o_data, o_count, o_overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d ovf=%b, want all 0",
                     o_valid, o_data, o_count, o_overflow);
        end
        i_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic;
        logic [W-1:0] w;
        w = 8'hA5;
        do_reset();
        for (int i = 0; i < W; i++) begin
            tick(1'b1, w[i], 1'b1);
            tests++;
            if (o_valid !== (i == W - 1) || o_data !== ((i == W - 1) ? w : 8'h00)) begin
                fails++;
                $display("FAIL basic_bit%0d: got v=%b d=%h, want v=%b d=%h",
                         i, o_valid, o_data, i == W - 1, (i == W - 1) ? w : 8'h00);
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        tests++;
        if (o_valid !== 1'b0 || got.size() != 1 || got[0] !== w) begin
            fails++;
            $display("FAIL basic_single_word: got v=%b n=%0d, want v=0 n=1 word a5",
                     o_valid, got.size());
        end
    endtask

    task automatic test_gapped;
        logic [W-1:0] w;
        int           peak;
        w    = 8'h3C;
        peak = 0;
        do_reset();
        for (int i = 0; i < W; i++) begin
            tick(1'b1, w[i], 1'b1);
            if (int'(o_count) > peak) peak = int'(o_count);
            tick(1'b0, 1'($urandom_range(1)), 1'b1);
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        tests++;
        if (peak != 1 || got.size() != 1 || got[0] !== w) begin
            fails++;
            $display("FAIL gapped_word: got peak=%0d n=%0d first=%h, want peak=1 n=1 word 3c",
                     peak, got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_full_simul;
        logic [W-1:0] w;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            w = W'(k);
            for (int i = 0; i < W; i++) tick(1'b1, w[i], 1'b0);
        end
        tests++;
        if (o_count !== 3'd4) begin
            fails++;
            $display("FAIL full_count: got %0d, want 4", o_count);
        end
        w = 8'h05;
        for (int i = 0; i < W; i++) tick(1'b1, w[i], i == W - 1);
        tests++;
        if (o_count !== 3'd4 || o_overflow !== 1'b0 || o_data !== 8'h02) begin
            fails++;
            $display("FAIL full_push_pop: got c=%0d ovf=%b d=%h, want c=4 ovf=0 d=02",
                     o_count, o_overflow, o_data);
        end
        repeat (6) tick(1'b0, 1'b0, 1'b1);
        tests++;
        if (got.size() != 5) begin
            fails++;
            $display("FAIL full_drain_count: got %0d words, want 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (got[k] !== W'(k + 1)) begin
                    fails++;
                    $display("FAIL full_order%0d: got %h, want %h", k, got[k], W'(k + 1));
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [W-1:0] w;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            w = W'(k);
            for (int i = 0; i < W; i++) tick(1'b1, w[i], 1'b0);
        end
        tests++;
        if (o_count !== 3'd4 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got c=%0d ovf=%b, want c=4 ovf=1", o_count, o_overflow);
        end
        repeat (6) tick(1'b0, 1'b0, 1'b1);
        tests++;
        if (got.size() != 4 || o_valid !== 1'b0 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drain: got n=%0d v=%b ovf=%b, want n=4 v=0 ovf=1",
                     got.size(), o_valid, o_overflow);
        end
        for (int k = 0; k < got.size(); k++) begin
            tests++;
            if (got[k] !== W'(k + 1)) begin
                fails++;
                $display("FAIL ovf_order%0d: got %h, want %h", k, got[k], W'(k + 1));
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [W-1:0] w;
        do_reset();
        w = 8'h77;
        for (int i = 0; i < W; i++) tick(1'b1, w[i], 1'b0);
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        tests++;
        if ({o_valid, o_data, o_count, o_overflow} !== '0) begin
            fails++;
            $display("FAIL midreset_async: got v=%b d=%h c=%0d ovf=%b, want all 0",
                     o_valid, o_data, o_count, o_overflow);
        end
        i_en = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_reset();
        w = 8'hF0;
        for (int i = 0; i < W; i++) tick(1'b1, w[i], 1'b1);
        tests++;
        if (o_data !== 8'hF0 || o_count !== 3'd1) begin
            fails++;
            $display("FAIL midreset_word: got d=%h c=%0d, want d=f0 c=1", o_data, o_count);
        end
    endtask

    task automatic test_wrap;
        logic [W-1:0] w;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            w = W'(8'h10 + k);
            for (int i = 0; i < W; i++) tick(1'b1, w[i], cyc[0]);
        end
        repeat (8) tick(1'b0, 1'b0, 1'b1);
        tests++;
        if (got.size() != 12 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL wrap_total: got n=%0d ovf=%b, want n=12 ovf=0", got.size(), o_overflow);
        end
        for (int k = 0; k < got.size(); k++) begin
            tests++;
            if (got[k] !== W'(8'h10 + k)) begin
                fails++;
                $display("FAIL wrap_order%0d: got %h, want %h", k, got[k], W'(8'h10 + k));
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] exp_d;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            tick(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(9) < 2));
            exp_d = (mq.size() != 0) ? mq[0] : '0;
            tests++;
            if (o_valid !== (mq.size() != 0) || o_data !== exp_d ||
                int'(o_count) != mq.size() || o_overflow !== m_ovf) begin
                fails++;
                $display("FAIL random_cyc%0d: got v=%b d=%h c=%0d ovf=%b, want v=%b d=%h c=%0d ovf=%b",
                         n, o_valid, o_data, o_count, o_overflow,
                         mq.size() != 0, exp_d, mq.size(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_full_simul();
        test_overflow();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter WIDTH, default 8: bits per packed word; legal range 2 to 32.
REQ-002 Parameter DEPTH, default 4: output FIFO entries; power of 2, at least 2.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_en  input  1  qualifies i_bit; a bit is consumed only on edges where i_en=1.
REQ-006 i_bit  input  1  serial data bit, from the upstream registered single-bit output; packed LSB-first.
REQ-007 o_data  output  WIDTH  FIFO head word.
REQ-008 o_valid  output  1  FIFO non-empty; o_data valid.
REQ-009 i_ready  input  1  consumer accepts o_data this cycle.
REQ-010 o_count  output  clog2(DEPTH+1)  number of words held in the FIFO.
REQ-011 o_overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 The block SHALL hold a bit counter (0..WIDTH-1) and a WIDTH-bit shift register.
REQ-013 On an edge with i_en=1, the block SHALL write i_bit into the shift register at bit index = counter.
  - Counter < WIDTH-1: counter increments.
  - Counter = WIDTH-1: counter wraps to 0.
REQ-014 On an edge with i_en=0, the counter and shift register SHALL hold.
REQ-015 The word is complete on the edge that consumes bit WIDTH-1. That word SHALL be pushed into the FIFO on that same edge, including the bit arriving on that edge.
REQ-016 Pop occurs on an edge where o_valid=1 and i_ready=1; the head entry SHALL be removed.
REQ-017 FIFO behaviour SHALL be first-word fall-through:
  - A word pushed into an empty FIFO gives o_valid=1 and o_data=word in the cycle after the push edge.
REQ-018 o_data SHALL be all zeros whenever o_valid=0.
REQ-019 o_count SHALL track occupancy exactly:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
REQ-020 Full (o_count=DEPTH), push, and pop on the same edge: both SHALL take effect; count stays DEPTH; no overflow.
REQ-021 Full, push, and no pop: the new word SHALL be discarded and the FIFO contents left unchanged. o_overflow SHALL go to 1 from the next cycle and remain 1 until reset.
REQ-022 The bit counter SHALL wrap normally on an overflowing push; packing continues without a gap.
REQ-023 Empty FIFO with i_ready=1 SHALL cause no state change.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-025 Latency from the edge consuming the last bit of a word to o_valid=1 SHALL be 1 cycle when the FIFO is empty.

Reset
REQ-026 While i_rst=1, regardless of clock, the following SHALL be forced to 0:
  - bit counter, shift register, FIFO pointers
  - o_count, o_valid, o_data, o_overflow
REQ-027 Reset in the middle of a word SHALL discard all partial bits; the first i_en=1 edge after release SHALL be bit 0 of a new word.
REQ-028 Reset SHALL discard all buffered words and clear o_overflow.
REQ-029 Release of i_rst SHALL be synchronous to i_clk (deassertion registered by the integrator); the block consumes no bit on the release edge unless i_en=1 after release.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Basic word: i_en=1 and i_ready=1, bits of 8'hA5 driven LSB-first on 8 consecutive edges -> o_valid=1 for exactly one cycle, the cycle after the 8th edge, with o_data=8'hA5.
REQ-031 Gapped enable: bits of 8'h3C with i_en=0 on alternating cycles and i_bit toggled randomly while i_en=0 -> single word 8'h3C; o_count peaks at 1.
REQ-032 Overflow: i_ready=0, words 8'h01..8'h05 streamed -> o_count=4 and o_overflow=1 after word 5. Then i_ready=1 -> pops 01, 02, 03, 04; o_valid drops; word 05 is never seen; o_overflow stays 1.
REQ-033 Full with simultaneous traffic: FIFO holding 4 words, i_ready=1 on the same edge word 5 completes -> o_count stays 4, o_overflow=0, word 5 delivered in order after words 2-4.
REQ-034 Mid-word reset: 3 bits consumed, then i_rst pulsed asynchronously between edges -> all outputs 0 immediately. The next 8 bits 8'hF0 -> o_data=8'hF0 with no residue from the prior 3 bits.
REQ-035 Wrap: 12 words 8'h10..8'h1B with i_ready toggling every cycle -> all 12 received in order, o_overflow=0.
